// File: rtl/rv_pkg.sv
// Shared decode definitions for the RV32I/RV64I(+M) decode stage: opcodes,
// ALU control layout, immediate formats and the decoded control bundle.
package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    // alu_ctrl = {UorS, RorL, AorS, LorA, op[9:0]}; each flag bit set means
    // unsigned / right / subtract(or negate branch compare) / arithmetic.
    localparam int ALU_U = 13;
    localparam int ALU_R = 12;
    localparam int ALU_S = 11;
    localparam int ALU_A = 10;

    localparam int OP_DIV   = 9;
    localparam int OP_MUL   = 8;
    localparam int OP_SHIFT = 7;
    localparam int OP_ADD   = 6;
    localparam int OP_SLT   = 5;
    localparam int OP_BGE   = 4;
    localparam int OP_AND   = 3;
    localparam int OP_OR    = 2;
    localparam int OP_XOR   = 1;
    localparam int OP_MOD   = 0;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_e;

    typedef enum logic [1:0] {
        OCC_EMPTY, OCC_MAIN, OCC_BOTH
    } occ_e;

    typedef struct packed {
        logic [4:0]  rd;
        logic        rf_we;
        logic [13:0] alu_ctrl;
        logic        s1_sel;
        logic        s2_sel;
        logic        mem_re;
        logic        mem_we;
        logic [2:0]  mem_size;
        logic        branch;
        logic        jump;
        logic        ebreak;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/rv_idu_stage_if.sv
// IFU-facing, EXU-facing and write-back signals of the decode stage.
interface rv_idu_stage_if #(parameter int XLEN = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            wb_we;
    logic [4:0]      wb_waddr;
    logic [XLEN-1:0] wb_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [4:0]      out_rd;
    logic            out_rf_we;
    logic [13:0]     out_alu_ctrl;
    logic            out_s1_sel;
    logic            out_s2_sel;
    logic            out_mem_re;
    logic            out_mem_we;
    logic [2:0]      out_mem_size;
    logic            out_branch;
    logic            out_jump;
    logic            out_ebreak;
    logic            out_illegal;

    modport slave (
        input  flush, in_valid, in_pc, in_inst, wb_we, wb_waddr, wb_wdata, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data, out_rd,
               out_rf_we, out_alu_ctrl, out_s1_sel, out_s2_sel, out_mem_re, out_mem_we,
               out_mem_size, out_branch, out_jump, out_ebreak, out_illegal
    );

    modport master (
        output flush, in_valid, in_pc, in_inst, wb_we, wb_waddr, wb_wdata, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1_data, out_rs2_data, out_rd,
               out_rf_we, out_alu_ctrl, out_s1_sel, out_s2_sel, out_mem_re, out_mem_we,
               out_mem_size, out_branch, out_jump, out_ebreak, out_illegal
    );
endinterface

// File: rtl/rv_idu_decode.sv
// Combinational instruction decoder: immediate, control bundle, operand usage and legality.
module rv_idu_decode
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm,
    output ctrl_t           ctrl,
    output logic            rs1_en,
    output logic            rs2_en
);
    localparam bit IS64 = (XLEN == 64);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [9:0] op;
    logic       f_u, f_r, f_s, f_a;
    logic       wr, ill, shamt_ok;
    imm_e       imm_type;

    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign funct7   = inst[31:25];
    assign shamt_ok = IS64 || !inst[25];

    always_comb begin
        op       = '0;
        {f_u, f_r, f_s, f_a} = 4'b0000;
        wr       = 1'b0;
        ill      = 1'b0;
        imm_type = IMM_NONE;
        rs1_en   = 1'b0;
        rs2_en   = 1'b0;
        ctrl     = '0;
        case (opcode)
            OPC_LUI: begin
                wr = 1'b1; ctrl.s2_sel = 1'b1; imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                wr = 1'b1; ctrl.s1_sel = 1'b1; ctrl.s2_sel = 1'b1; imm_type = IMM_U;
            end
            OPC_JAL: begin
                wr = 1'b1; ctrl.jump = 1'b1; ctrl.s1_sel = 1'b1; imm_type = IMM_J;
            end
            OPC_JALR: begin
                wr = 1'b1; ctrl.jump = 1'b1; ctrl.s2_sel = 1'b1; rs1_en = 1'b1;
                imm_type = IMM_I; ill = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; imm_type = IMM_B;
                case (funct3)
                    3'b000: op[OP_XOR] = 1'b1;
                    3'b001: begin op[OP_XOR] = 1'b1; f_s = 1'b1; end
                    3'b100: op[OP_SLT] = 1'b1;
                    3'b101: op[OP_BGE] = 1'b1;
                    3'b110: begin op[OP_SLT] = 1'b1; f_u = 1'b1; end
                    3'b111: begin op[OP_BGE] = 1'b1; f_u = 1'b1; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                wr = 1'b1; ctrl.mem_re = 1'b1; ctrl.s2_sel = 1'b1; rs1_en = 1'b1;
                imm_type = IMM_I; ctrl.mem_size = funct3;
                case (funct3)
                    3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill = 1'b0;
                    3'b011, 3'b110:                         ill = !IS64;
                    default:                                ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.mem_we = 1'b1; ctrl.s2_sel = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1;
                imm_type = IMM_S; ctrl.mem_size = funct3;
                case (funct3)
                    3'b000, 3'b001, 3'b010: ill = 1'b0;
                    3'b011:                 ill = !IS64;
                    default:                ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                wr = 1'b1; ctrl.s2_sel = 1'b1; rs1_en = 1'b1; imm_type = IMM_I;
                case (funct3)
                    3'b000: op[OP_ADD] = 1'b1;
                    3'b010: op[OP_SLT] = 1'b1;
                    3'b011: begin op[OP_SLT] = 1'b1; f_u = 1'b1; end
                    3'b100: op[OP_XOR] = 1'b1;
                    3'b110: op[OP_OR]  = 1'b1;
                    3'b111: op[OP_AND] = 1'b1;
                    3'b001: begin
                        op[OP_SHIFT] = 1'b1;
                        ill = !(inst[31:26] == 6'b000000 && shamt_ok);
                    end
                    default: begin
                        op[OP_SHIFT] = 1'b1; f_r = 1'b1; f_a = inst[30];
                        ill = !((inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000) && shamt_ok);
                    end
                endcase
            end
            OPC_OP: begin
                wr = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1;
                if (funct7 == 7'b0000001) begin
                    ill = !EN_M;
                    case (funct3)
                        3'b000: op[OP_MUL] = 1'b1;
                        3'b001: begin op[OP_MUL] = 1'b1; f_r = 1'b1; end
                        3'b010: begin op[OP_MUL] = 1'b1; f_r = 1'b1; f_a = 1'b1; end
                        3'b011: begin op[OP_MUL] = 1'b1; f_r = 1'b1; f_u = 1'b1; end
                        3'b100: op[OP_DIV] = 1'b1;
                        3'b101: begin op[OP_DIV] = 1'b1; f_u = 1'b1; end
                        3'b110: op[OP_MOD] = 1'b1;
                        default: begin op[OP_MOD] = 1'b1; f_u = 1'b1; end
                    endcase
                end else if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: op[OP_ADD]   = 1'b1;
                        3'b001: op[OP_SHIFT] = 1'b1;
                        3'b010: op[OP_SLT]   = 1'b1;
                        3'b011: begin op[OP_SLT] = 1'b1; f_u = 1'b1; end
                        3'b100: op[OP_XOR]   = 1'b1;
                        3'b101: begin op[OP_SHIFT] = 1'b1; f_r = 1'b1; end
                        3'b110: op[OP_OR]    = 1'b1;
                        default: op[OP_AND]  = 1'b1;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    op[OP_ADD] = 1'b1; f_s = 1'b1;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    op[OP_SHIFT] = 1'b1; f_r = 1'b1; f_a = 1'b1;
                end else begin
                    ill = 1'b1;
                end
            end
            OPC_MISC_MEM: ill = 1'b0;
            OPC_SYSTEM: begin
                ctrl.ebreak = (inst == EBREAK);
                ill         = (inst != EBREAK);
            end
            // OP-32/OP-IMM-32 land here: the bundle carries no word-size flag, so they trap.
            default: ill = 1'b1;
        endcase

        if (op == '0) op[OP_ADD] = 1'b1;
        ctrl.rd       = inst[11:7];
        ctrl.alu_ctrl = {f_u, f_r, f_s, f_a, op};
        ctrl.illegal  = ill;
        ctrl.rf_we    = wr && (inst[11:7] != 5'd0) && !ill;
        if (ill) begin
            ctrl.mem_re = 1'b0;
            ctrl.mem_we = 1'b0;
            ctrl.branch = 1'b0;
            ctrl.jump   = 1'b0;
        end
    end

    always_comb begin
        case (imm_type)
            IMM_I:   imm = {{(XLEN-11){inst[31]}}, inst[30:20]};
            IMM_S:   imm = {{(XLEN-11){inst[31]}}, inst[30:25], inst[11:7]};
            IMM_B:   imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {{(XLEN-31){inst[31]}}, inst[30:12], 12'b0};
            IMM_J:   imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/ysyx22041405_regfile.sv
// 32 x XLEN integer register file: one write port, two asynchronous read ports, x0 hardwired to 0.
module ysyx22041405_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    logic [XLEN-1:0] regs [1:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

// File: rtl/rv_idu_stage.sv
// Decode stage between IFU and EXU: decode, regfile read with write-back bypass,
// and a main + optional skid entry holding decoded bundles in FIFO order.
//   state     | meaning
//   OCC_EMPTY | no bundle held, out_valid=0
//   OCC_MAIN  | main entry valid and presented to EXU
//   OCC_BOTH  | main presented, skid holds the next bundle, in_ready=0
module rv_idu_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit EN_M = 1'b1,
    parameter bit SKID = 1'b1
) (
    input logic           clk,
    input logic           rst,
    rv_idu_stage_if.slave bus
);
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("rv_idu_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        ctrl_t           ctrl;
    } entry_t;

    logic [XLEN-1:0] dec_imm, rf_rdata1, rf_rdata2, rs1_val, rs2_val;
    ctrl_t           dec_ctrl;
    logic            dec_rs1_en, dec_rs2_en;
    logic [4:0]      rs1, rs2;
    occ_e            occ_q, occ_d;
    entry_t          main_q, main_d, skid_q, skid_d, new_e;
    logic            main_v, in_ready, accept, drain;

    assign rs1 = bus.in_inst[19:15];
    assign rs2 = bus.in_inst[24:20];

    rv_idu_decode #(.XLEN(XLEN), .EN_M(EN_M)) u_decode (
        .inst   (bus.in_inst),
        .imm    (dec_imm),
        .ctrl   (dec_ctrl),
        .rs1_en (dec_rs1_en),
        .rs2_en (dec_rs2_en)
    );

    ysyx22041405_regfile #(.XLEN(XLEN)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.wb_we),
        .waddr  (bus.wb_waddr),
        .wdata  (bus.wb_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Unused operand fields (e.g. lui's rs1 bits) read as 0 rather than a stray register.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (dec_rs1_en && rs1 != 5'd0)
            rs1_val = (bus.wb_we && bus.wb_waddr == rs1) ? bus.wb_wdata : rf_rdata1;
        if (dec_rs2_en && rs2 != 5'd0)
            rs2_val = (bus.wb_we && bus.wb_waddr == rs2) ? bus.wb_wdata : rf_rdata2;
    end

    assign new_e  = '{pc: bus.in_pc, imm: dec_imm, rs1_data: rs1_val, rs2_data: rs2_val, ctrl: dec_ctrl};
    assign main_v = (occ_q != OCC_EMPTY);
    assign in_ready = SKID ? (occ_q != OCC_BOTH) : (!main_v || bus.out_ready);
    assign accept = bus.in_valid && in_ready;
    assign drain  = main_v && bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (accept) begin
                    main_d = new_e;
                    occ_d  = OCC_MAIN;
                end
            end
            OCC_MAIN: begin
                if (drain && accept) begin
                    main_d = new_e;
                end else if (drain) begin
                    occ_d = OCC_EMPTY;
                end else if (SKID && accept) begin
                    skid_d = new_e;
                    occ_d  = OCC_BOTH;
                end
            end
            OCC_BOTH: begin
                if (drain) begin
                    main_d = skid_q;
                    occ_d  = OCC_MAIN;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
        if (bus.flush) occ_d = OCC_EMPTY;
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = main_v;
    assign bus.out_pc       = main_q.pc;
    assign bus.out_imm      = main_q.imm;
    assign bus.out_rs1_data = main_q.rs1_data;
    assign bus.out_rs2_data = main_q.rs2_data;
    assign bus.out_rd       = main_q.ctrl.rd;
    assign bus.out_rf_we    = main_q.ctrl.rf_we;
    assign bus.out_alu_ctrl = main_q.ctrl.alu_ctrl;
    assign bus.out_s1_sel   = main_q.ctrl.s1_sel;
    assign bus.out_s2_sel   = main_q.ctrl.s2_sel;
    assign bus.out_mem_re   = main_q.ctrl.mem_re;
    assign bus.out_mem_we   = main_q.ctrl.mem_we;
    assign bus.out_mem_size = main_q.ctrl.mem_size;
    assign bus.out_branch   = main_q.ctrl.branch;
    assign bus.out_jump     = main_q.ctrl.jump;
    assign bus.out_ebreak   = main_q.ctrl.ebreak;
    assign bus.out_illegal  = main_q.ctrl.illegal;
endmodule

// File: tb/tb_rv_idu_stage.sv
// Directed bench for rv_idu_stage: reset, streaming, bypass, skid back-pressure, flush and decode corners.
module tb_rv_idu_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rv_idu_stage_if #(.XLEN(32)) bus ();
    rv_idu_stage_if #(.XLEN(32)) bus_nom ();

    rv_idu_stage #(.XLEN(32), .EN_M(1'b1), .SKID(1'b1)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    rv_idu_stage #(.XLEN(32), .EN_M(1'b0), .SKID(1'b0)) dut_nom (
        .clk (clk), .rst (rst), .bus (bus_nom)
    );

    localparam logic [31:0] I_ADDI_X1  = 32'hFFB0_0093; // addi x1,x0,-5
    localparam logic [31:0] I_ADD_X2   = 32'h0010_8133; // add x2,x1,x1
    localparam logic [31:0] I_ADD_X3   = 32'h0002_81B3; // add x3,x5,x0
    localparam logic [31:0] I_MUL      = 32'h0231_00B3; // mul x1,x2,x3
    localparam logic [31:0] I_SLLI_BAD = 32'h0230_9093; // slli x1,x1,3 with inst[25]=1
    localparam logic [31:0] I_SLLI     = 32'h0030_9093; // slli x1,x1,3
    localparam logic [31:0] I_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] I_SW       = 32'h0020_A423; // sw x2,8(x1)
    localparam logic [31:0] I_JAL      = 32'hFFDF_F0EF; // jal x1,-4
    localparam logic [31:0] I_LUI      = 32'h1234_52B7; // lui x5,0x12345 (rs1 field = x8)

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.in_pc = '0; bus.in_inst = '0;
        bus.wb_we = 0; bus.wb_waddr = '0; bus.wb_wdata = '0; bus.out_ready = 0;
        bus_nom.flush = 0; bus_nom.in_valid = 0; bus_nom.in_pc = '0; bus_nom.in_inst = '0;
        bus_nom.wb_we = 0; bus_nom.wb_waddr = '0; bus_nom.wb_wdata = '0; bus_nom.out_ready = 0;

        step(); step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_pc", bus.out_pc, 0);
        chk("rst_alu_ctrl", bus.out_alu_ctrl, 0);
        rst = 1'b1;
        step();

        // Back-to-back stream with EXU always ready; the EN_M=0 copy decodes mul alongside.
        bus.out_ready = 1; bus_nom.out_ready = 1;
        bus_nom.in_valid = 1; bus_nom.in_pc = 32'h80; bus_nom.in_inst = I_MUL;
        bus.in_valid = 1; bus.in_pc = 32'h100; bus.in_inst = I_ADDI_X1;
        step();
        bus_nom.in_valid = 0;
        chk("nom_mul_valid", bus_nom.out_valid, 1);
        chk("nom_mul_illegal", bus_nom.out_illegal, 1);
        chk("nom_mul_rf_we", bus_nom.out_rf_we, 0);
        chk("addi_valid", bus.out_valid, 1);
        chk("addi_pc", bus.out_pc, 32'h100);
        chk("addi_imm", bus.out_imm, 32'hFFFF_FFFB);
        chk("addi_alu", bus.out_alu_ctrl, 14'h0040);
        chk("addi_s2_sel", bus.out_s2_sel, 1);
        chk("addi_rd", bus.out_rd, 1);
        chk("addi_rf_we", bus.out_rf_we, 1);
        bus.in_pc = 32'h104; bus.in_inst = I_ADD_X2;
        step();
        chk("add_valid", bus.out_valid, 1);
        chk("add_pc", bus.out_pc, 32'h104);
        chk("add_alu", bus.out_alu_ctrl, 14'h0040);
        chk("add_s2_sel", bus.out_s2_sel, 0);
        chk("add_imm", bus.out_imm, 0);
        chk("add_rd", bus.out_rd, 2);
        bus.in_valid = 0;
        step();
        chk("stream_drained", bus.out_valid, 0);

        // Write-back bypass at capture, then the same read straight from the regfile.
        bus.in_valid = 1; bus.in_pc = 32'h200; bus.in_inst = I_ADD_X3;
        bus.wb_we = 1; bus.wb_waddr = 5'd5; bus.wb_wdata = 32'hDEAD_BEEF;
        step();
        bus.wb_we = 0;
        chk("byp_rs1", bus.out_rs1_data, 32'hDEAD_BEEF);
        chk("byp_rs2", bus.out_rs2_data, 0);
        chk("byp_rd", bus.out_rd, 3);
        bus.in_pc = 32'h204;
        step();
        chk("rf_rs1", bus.out_rs1_data, 32'hDEAD_BEEF);
        chk("rf_pc", bus.out_pc, 32'h204);
        bus.in_valid = 0;
        step();

        // Skid: EXU stalls while IFU pushes three; in_ready falls after the second.
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_pc = 32'h300; bus.in_inst = I_ADDI_X1;
        chk("skid_rdy0", bus.in_ready, 1);
        step();
        chk("skid_pc_a", bus.out_pc, 32'h300);
        chk("skid_rdy1", bus.in_ready, 1);
        bus.in_pc = 32'h304; bus.in_inst = I_ADD_X2;
        step();
        chk("skid_rdy2", bus.in_ready, 0);
        chk("skid_hold_pc1", bus.out_pc, 32'h300);
        bus.in_pc = 32'h308; bus.in_inst = I_SLLI;
        step();
        chk("skid_rdy3", bus.in_ready, 0);
        chk("skid_hold_pc2", bus.out_pc, 32'h300);
        chk("skid_hold_imm", bus.out_imm, 32'hFFFF_FFFB);
        chk("skid_hold_valid", bus.out_valid, 1);
        bus.out_ready = 1;
        step();
        chk("skid_pc_b", bus.out_pc, 32'h304);
        chk("skid_rdy4", bus.in_ready, 1);
        step();
        chk("skid_pc_c", bus.out_pc, 32'h308);
        chk("skid_alu_c", bus.out_alu_ctrl, 14'h0080);
        bus.in_valid = 0;
        step();
        chk("skid_empty", bus.out_valid, 0);

        // Flush with both entries full and an offer pending.
        bus.out_ready = 0;
        bus.in_valid = 1; bus.in_pc = 32'h400;
        step();
        bus.in_pc = 32'h404;
        step();
        chk("flush_full", bus.in_ready, 0);
        bus.in_pc = 32'h408; bus.flush = 1;
        step();
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_rdy", bus.in_ready, 1);
        bus.flush = 0; bus.in_valid = 0; bus.out_ready = 1;
        step();
        chk("flush_no_emit", bus.out_valid, 0);
        bus.in_valid = 1; bus.in_pc = 32'h500; bus.flush = 1;
        step();
        chk("flush_drop_accept", bus.out_valid, 0);
        bus.flush = 0; bus.in_valid = 0;
        step();

        // Decode corners.
        issue(32'h600, I_SLLI_BAD);
        chk("slli25_illegal", bus.out_illegal, 1);
        chk("slli25_rf_we", bus.out_rf_we, 0);
        issue(32'h604, I_SLLI);
        chk("slli_illegal", bus.out_illegal, 0);
        chk("slli_alu", bus.out_alu_ctrl, 14'h0080);
        chk("slli_imm", bus.out_imm, 3);
        issue(32'h608, I_EBREAK);
        chk("ebreak", bus.out_ebreak, 1);
        chk("ebreak_illegal", bus.out_illegal, 0);
        chk("ebreak_rf_we", bus.out_rf_we, 0);
        issue(32'h60C, I_SW);
        chk("sw_mem_we", bus.out_mem_we, 1);
        chk("sw_size", bus.out_mem_size, 2);
        chk("sw_imm", bus.out_imm, 8);
        chk("sw_rf_we", bus.out_rf_we, 0);
        issue(32'h610, I_JAL);
        chk("jal_jump", bus.out_jump, 1);
        chk("jal_s1", bus.out_s1_sel, 1);
        chk("jal_imm", bus.out_imm, 32'hFFFF_FFFC);
        bus.wb_we = 1; bus.wb_waddr = 5'd8; bus.wb_wdata = 32'h55;
        issue(32'h614, I_LUI);
        bus.wb_we = 0;
        chk("lui_imm", bus.out_imm, 32'h1234_5000);
        chk("lui_rs1", bus.out_rs1_data, 0);
        chk("lui_s1", bus.out_s1_sel, 0);
        chk("lui_s2", bus.out_s2_sel, 1);
        chk("lui_rd", bus.out_rd, 5);
        issue(32'h618, I_MUL);
        chk("mul_illegal", bus.out_illegal, 0);
        chk("mul_alu", bus.out_alu_ctrl, 14'h0100);
        chk("mul_rf_we", bus.out_rf_we, 1);

        // Asynchronous reset while a bundle is held.
        bus.out_ready = 0;
        issue(32'h700, I_ADDI_X1);
        chk("mid_valid", bus.out_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_rdy", bus.in_ready, 1);
        chk("arst_pc", bus.out_pc, 0);
        chk("arst_imm", bus.out_imm, 0);
        rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
